vsdriscv_cpu: RTL and testbench



---
 rtl/vsdriscv_cpu.sv | 207 ++++++++++++++++++++
 tb/tb_vsdriscv_cpu.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsdriscv_cpu.sv
// Single-cycle RV64I-subset demonstrator core with a hard-wired 16-word ROM; x7 drives result.
// Optional shifts (SLL/SRL/SRA and immediate forms) are built when VSDRISCV_SHIFT_EN is defined.
module vsdriscv_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] result
);

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    logic [63:0] r_pc;
    logic [63:0] r_regs [0:31];

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [63:0] w_immI;
    logic [63:0] w_immU;
    logic [63:0] w_immB;
    logic [63:0] w_immJ;
    logic [63:0] w_rs1Val;
    logic [63:0] w_rs2Val;
    logic [63:0] w_aluB;
    logic        w_aluLt;
    logic        w_aluLtu;
    logic        w_brEq;
    logic        w_brLt;
    logic        w_brLtu;
    logic        w_brTaken;
    logic [63:0] w_pcPlus4;
    logic [63:0] w_nextPc;
    logic        w_wrEn;
    logic [63:0] w_wrData;
`ifdef VSDRISCV_SHIFT_EN
    logic [5:0]  w_shamt;
`endif

    // Program ROM; anything fetched at or beyond byte address 64 is a NOP.
    always_comb begin
        w_instr = NOP_INSTR;
        if (r_pc[63:6] == 58'd0) begin
            case (r_pc[5:2])
                4'd0:    w_instr = 32'h0050_0093;
                4'd1:    w_instr = 32'h0030_0113;
                4'd2:    w_instr = 32'h0020_81B3;
                4'd3:    w_instr = 32'h4020_8233;
                4'd4:    w_instr = 32'h0020_F2B3;
                4'd5:    w_instr = 32'h0020_E333;
                4'd6:    w_instr = 32'h0061_83B3;
                4'd7:    w_instr = 32'h0000_0063;
                default: w_instr = NOP_INSTR;
            endcase
        end
    end

    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];

    assign w_immI = {{52{w_instr[31]}}, w_instr[31:20]};
    assign w_immU = {{32{w_instr[31]}}, w_instr[31:12], 12'h000};
    assign w_immB = {{51{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_immJ = {{43{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    // x0 is never written, so reading the array directly yields zero for it.
    assign w_rs1Val = r_regs[w_rs1];
    assign w_rs2Val = r_regs[w_rs2];

    assign w_aluB    = (w_opcode == OPC_OP) ? w_rs2Val : w_immI;
    assign w_aluLt   = $signed(w_rs1Val) < $signed(w_aluB);
    assign w_aluLtu  = w_rs1Val < w_aluB;
    assign w_brEq    = w_rs1Val == w_rs2Val;
    assign w_brLt    = $signed(w_rs1Val) < $signed(w_rs2Val);
    assign w_brLtu   = w_rs1Val < w_rs2Val;
    assign w_pcPlus4 = r_pc + 64'd4;
`ifdef VSDRISCV_SHIFT_EN
    assign w_shamt   = w_aluB[5:0];
`endif

    always_comb begin
        w_brTaken = 1'b0;
        case (w_funct3)
            3'b000:  w_brTaken = w_brEq;
            3'b001:  w_brTaken = !w_brEq;
            3'b100:  w_brTaken = w_brLt;
            3'b101:  w_brTaken = !w_brLt;
            3'b110:  w_brTaken = w_brLtu;
            3'b111:  w_brTaken = !w_brLtu;
            default: w_brTaken = 1'b0;
        endcase
    end

    // Execute: anything not decoded below falls through as a NOP.
    always_comb begin
        w_wrEn   = 1'b0;
        w_wrData = 64'd0;
        w_nextPc = w_pcPlus4;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == 7'b0000000) begin
                    w_wrEn = 1'b1;
                    case (w_funct3)
                        3'b000:  w_wrData = w_rs1Val + w_rs2Val;
                        3'b010:  w_wrData = {63'd0, w_aluLt};
                        3'b011:  w_wrData = {63'd0, w_aluLtu};
                        3'b100:  w_wrData = w_rs1Val ^ w_rs2Val;
                        3'b110:  w_wrData = w_rs1Val | w_rs2Val;
                        3'b111:  w_wrData = w_rs1Val & w_rs2Val;
`ifdef VSDRISCV_SHIFT_EN
                        3'b001:  w_wrData = w_rs1Val << w_shamt;
                        3'b101:  w_wrData = w_rs1Val >> w_shamt;
`endif
                        default: w_wrEn = 1'b0;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    case (w_funct3)
                        3'b000: begin
                            w_wrEn   = 1'b1;
                            w_wrData = w_rs1Val - w_rs2Val;
                        end
`ifdef VSDRISCV_SHIFT_EN
                        3'b101: begin
                            w_wrEn   = 1'b1;
                            w_wrData = $unsigned($signed(w_rs1Val) >>> w_shamt);
                        end
`endif
                        default: w_wrEn = 1'b0;
                    endcase
                end
            end
            OPC_OPIMM: begin
                w_wrEn = 1'b1;
                case (w_funct3)
                    3'b000:  w_wrData = w_rs1Val + w_immI;
                    3'b010:  w_wrData = {63'd0, w_aluLt};
                    3'b011:  w_wrData = {63'd0, w_aluLtu};
                    3'b100:  w_wrData = w_rs1Val ^ w_immI;
                    3'b110:  w_wrData = w_rs1Val | w_immI;
                    3'b111:  w_wrData = w_rs1Val & w_immI;
`ifdef VSDRISCV_SHIFT_EN
                    3'b001: begin
                        w_wrEn   = (w_instr[31:26] == 6'b000000);
                        w_wrData = w_rs1Val << w_shamt;
                    end
                    3'b101: begin
                        if (w_instr[31:26] == 6'b000000) begin
                            w_wrData = w_rs1Val >> w_shamt;
                        end else if (w_instr[31:26] == 6'b010000) begin
                            w_wrData = $unsigned($signed(w_rs1Val) >>> w_shamt);
                        end else begin
                            w_wrEn = 1'b0;
                        end
                    end
`endif
                    default: w_wrEn = 1'b0;
                endcase
            end
            OPC_LUI: begin
                w_wrEn   = 1'b1;
                w_wrData = w_immU;
            end
            OPC_JAL: begin
                w_wrEn   = 1'b1;
                w_wrData = w_pcPlus4;
                w_nextPc = r_pc + w_immJ;
            end
            OPC_BRANCH: begin
                if (w_brTaken) begin
                    w_nextPc = r_pc + w_immB;
                end
            end
            default: begin
                w_wrEn = 1'b0;
            end
        endcase
    end

    // Commit: rd write and PC update land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 64'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 64'd0;
            end
        end else begin
            r_pc <= w_nextPc;
            if (w_wrEn && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wrData;
            end
        end
    end

    assign result = r_regs[7];

endmodule

// File: tb/tb_vsdriscv_cpu.sv
// Self-checking bench for vsdriscv_cpu: ROM program timing, async reset, and forced random
// instructions checked against an ISA-level model (shift expectations follow VSDRISCV_SHIFT_EN).
module tb_vsdriscv_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] result;
    logic [31:0] forcedInstr = 32'h0000_0013;

    int checkCount = 0;
    int failCount  = 0;

`ifdef VSDRISCV_SHIFT_EN
    localparam bit ShiftEn = 1'b1;
`else
    localparam bit ShiftEn = 1'b0;
`endif

    typedef struct {
        int          edges;
        logic [63:0] expResult;
        logic [63:0] expPc;
    } vec_t;

    vec_t vecs[$];

    logic [63:0] progVals [8] = '{64'd0, 64'd5, 64'd3, 64'd8, 64'd2, 64'd1, 64'd7, 64'd15};
    logic [63:0] mRegs [32];
    logic [63:0] mPc;

    vsdriscv_cpu dut (
        .clk    (clk),
        .reset  (reset),
        .result (result)
    );

    always #5 clk = ~clk;

    // Watchdog so a broken run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Program outcome after n edges since reset release: register k is written at edge k.
    function automatic logic [63:0] expReg(input int idx, input int n);
        if (idx >= 1 && idx <= 7 && n >= idx) return progVals[idx];
        return 64'd0;
    endfunction

    function automatic logic [63:0] expPcAfter(input int n);
        return (n >= 7) ? 64'h1C : 64'(4 * n);
    endfunction

    // Pulse reset asynchronously between edges, then run the requested number of edges.
    task automatic applyStimulus(input int edges);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 checkOutput("resetAsyncResult", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
    endtask

    function automatic bit signedLess(input logic [63:0] a, input logic [63:0] b);
        if (a[63] != b[63]) return a[63];
        return a < b;
    endfunction

    function automatic logic [63:0] arithShiftRight(input logic [63:0] a, input logic [5:0] s);
        logic [63:0] fill;
        fill = a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s) : 64'd0;
        return (a >> s) | fill;
    endfunction

    // ISA-level reference: one instruction applied to mRegs/mPc.
    task automatic modelStep(input logic [31:0] ins);
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] immI;
        logic [63:0] y;
        logic [63:0] nextPc;
        bit          ok;
        bit          taken;
        op     = ins[6:0];
        rd     = ins[11:7];
        f3     = ins[14:12];
        f7     = ins[31:25];
        a      = mRegs[ins[19:15]];
        b      = mRegs[ins[24:20]];
        immI   = {{52{ins[31]}}, ins[31:20]};
        y      = 64'd0;
        ok     = 1'b0;
        taken  = 1'b0;
        nextPc = mPc + 64'd4;
        if (op == 7'h33) begin
            ok = 1'b1;
            case ({f7, f3})
                {7'h00, 3'd0}: y = a + b;
                {7'h20, 3'd0}: y = a - b;
                {7'h00, 3'd4}: y = a ^ b;
                {7'h00, 3'd6}: y = a | b;
                {7'h00, 3'd7}: y = a & b;
                {7'h00, 3'd2}: y = signedLess(a, b) ? 64'd1 : 64'd0;
                {7'h00, 3'd3}: y = (a < b) ? 64'd1 : 64'd0;
                {7'h00, 3'd1}: begin ok = ShiftEn; y = a << b[5:0]; end
                {7'h00, 3'd5}: begin ok = ShiftEn; y = a >> b[5:0]; end
                {7'h20, 3'd5}: begin ok = ShiftEn; y = arithShiftRight(a, b[5:0]); end
                default:       ok = 1'b0;
            endcase
        end else if (op == 7'h13) begin
            ok = 1'b1;
            case (f3)
                3'd0: y = a + immI;
                3'd2: y = signedLess(a, immI) ? 64'd1 : 64'd0;
                3'd3: y = (a < immI) ? 64'd1 : 64'd0;
                3'd4: y = a ^ immI;
                3'd6: y = a | immI;
                3'd7: y = a & immI;
                3'd1: begin
                    ok = ShiftEn && (ins[31:26] == 6'h00);
                    y  = a << immI[5:0];
                end
                default: begin
                    ok = ShiftEn && (ins[31:26] == 6'h00 || ins[31:26] == 6'h10);
                    y  = (ins[30]) ? arithShiftRight(a, immI[5:0]) : (a >> immI[5:0]);
                end
            endcase
        end else if (op == 7'h37) begin
            ok = 1'b1;
            y  = {{32{ins[31]}}, ins[31:12], 12'h000};
        end else if (op == 7'h6F) begin
            ok     = 1'b1;
            y      = mPc + 64'd4;
            nextPc = mPc + {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end else if (op == 7'h63) begin
            case (f3)
                3'd0:    taken = (a == b);
                3'd1:    taken = (a != b);
                3'd4:    taken = signedLess(a, b);
                3'd5:    taken = !signedLess(a, b);
                3'd6:    taken = (a < b);
                3'd7:    taken = !(a < b);
                default: taken = 1'b0;
            endcase
            if (taken) nextPc = mPc + {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        if (ok && rd != 5'd0) mRegs[rd] = y;
        mPc = nextPc;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] rnd;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [6:0]  badOps [5];
        int          kind;
        badOps = '{7'h03, 7'h23, 7'h73, 7'h1B, 7'h67};
        rnd  = $urandom;
        rd   = 5'($urandom_range(0, 31));
        rs1  = 5'($urandom_range(0, 31));
        rs2  = 5'($urandom_range(0, 31));
        f3   = 3'($urandom_range(0, 7));
        kind = $urandom_range(0, 9);
        f7   = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        imm  = rnd[11:0];
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:6] = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h10;
        case (kind)
            0, 1, 2: return {f7, rs2, rs1, f3, rd, 7'h33};
            3, 4, 5: return {imm, rs1, f3, rd, 7'h13};
            6:       return {rnd[31:12], rd, 7'h37};
            7:       return {rnd[31:12], rd, 7'h6F};
            8:       return {rnd[31:25], rs2, rs1, f3, rnd[11:7], 7'h63};
            default: return {rnd[31:7], badOps[$urandom_range(0, 4)]};
        endcase
    endfunction

    initial begin
        int k;
        int m;
        logic [31:0] ins;

        vecs.push_back('{0,  64'd0,  64'h00});
        vecs.push_back('{1,  64'd0,  64'h04});
        vecs.push_back('{3,  64'd0,  64'h0C});
        vecs.push_back('{6,  64'd0,  64'h18});
        vecs.push_back('{7,  64'd15, 64'h1C});
        vecs.push_back('{8,  64'd15, 64'h1C});
        vecs.push_back('{17, 64'd15, 64'h1C});

        // Reset held while the clock runs: nothing may change.
        #2 checkOutput("resetResult", result, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetHoldResult", result, 64'd0);
        checkOutput("resetHoldPc", dut.r_pc, 64'd0);
        checkOutput("resetHoldX1", dut.r_regs[1], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 checkOutput("firstEdgeX1", dut.r_regs[1], 64'd5);
        repeat (2) @(posedge clk);
        #1 checkOutput("thirdEdgeX3", dut.r_regs[3], 64'd8);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].edges);
            checkOutput($sformatf("vec%0d_result", i), result, vecs[i].expResult);
            checkOutput($sformatf("vec%0d_pc", i), dut.r_pc, vecs[i].expPc);
        end

        // Full program, then the halt loop must hold.
        applyStimulus(12);
        for (int r = 0; r < 8; r++) begin
            checkOutput($sformatf("progX%0d", r), dut.r_regs[r], expReg(r, 12));
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("haltPc", dut.r_pc, 64'h1C);
            checkOutput("haltResult", result, 64'd15);
        end

        // Reset landing between edges mid-program.
        applyStimulus(4);
        #2 reset = 1'b1;
        #1;
        checkOutput("midResetResult", result, 64'd0);
        checkOutput("midResetX4", dut.r_regs[4], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1 checkOutput("midResetRerun", result, 64'd15);

        // Randomised reset placement checked against the program timeline.
        for (int t = 0; t < 8; t++) begin
            k = $urandom_range(0, 10);
            m = $urandom_range(0, 10);
            applyStimulus(k);
            checkOutput("randPreResult", result, expReg(7, k));
            checkOutput("randPreX3", dut.r_regs[3], expReg(3, k));
            #($urandom_range(1, 3)) reset = 1'b1;
            #1 checkOutput("randResetResult", result, 64'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (m) @(posedge clk);
            #1;
            checkOutput("randPostResult", result, expReg(7, m));
            checkOutput("randPostPc", dut.r_pc, expPcAfter(m));
        end

        // slli x7,x1,2 dropped into the halt slot.
        applyStimulus(8);
        @(negedge clk);
        forcedInstr = 32'h0020_9393;
        force dut.w_instr = forcedInstr;
        @(posedge clk);
        #1 release dut.w_instr;
        checkOutput("slliResult", result, ShiftEn ? 64'd20 : 64'd15);
        checkOutput("slliPc", dut.r_pc, 64'h20);

        // Random instruction stream against the ISA model.
        applyStimulus(8);
        for (int r = 0; r < 32; r++) mRegs[r] = expReg(r, 8);
        mPc = 64'h1C;
        for (int n = 0; n < 80; n++) begin
            ins = randInstr();
            @(negedge clk);
            forcedInstr = ins;
            force dut.w_instr = forcedInstr;
            @(posedge clk);
            #1 release dut.w_instr;
            modelStep(ins);
            checkOutput($sformatf("rnd%0d_pc(0x%08h)", n, ins), dut.r_pc, mPc);
            checkOutput($sformatf("rnd%0d_rd(0x%08h)", n, ins), dut.r_regs[ins[11:7]], mRegs[ins[11:7]]);
            checkOutput($sformatf("rnd%0d_result(0x%08h)", n, ins), result, mRegs[7]);
        end
        checkOutput("rndX0", dut.r_regs[0], 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
